m_stage_dm: RTL and testbench
=============================

Name: m_stage_dm

Overview:
- Memory stage of the 5-stage MIPS pipeline.
- Holds the word-addressed data memory and performs sw/sh/sb stores with byte lanes.
- Performs lw/lh/lhu/lb/lbu loads with sign/zero extension.
- Contains the M/W pipeline register that feeds the write-back stage (IR, pc, pc4, ALUout, DMout to W).

Parameters:
- DM_WORDS, 4096, number of 32-bit words in data memory; index = addr[log2(DM_WORDS)+1:2]
- ADDR_BASE, 32'h0000_0000, byte address of word 0; subtracted before indexing

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- IR_M  in  32  instruction in M
- pc_M  in  32  pc of instruction in M
- pc4_M  in  32  pc+4 of instruction in M
- ALUout_M  in  32  ALU result; byte address for loads/stores
- WD_M  in  32  store data (rt, already forwarded)
- MemWrite_M  in  1  store enable
- save_sel_M  in  2  store width code
- load_sel_M  in  3  load extension code
- IR_W  out  32  registered IR to W
- pc_W  out  32  registered pc
- pc4_W  out  32  registered pc4
- ALUout_W  out  32  registered ALUout
- DMout_W  out  32  registered, extended load data

Behaviour:
- Reset (reset==0, async): all five outputs go to 0 immediately. Every memory word is cleared to 0. IR_W==0 decodes as nop in W, so no register write occurs.
- M/W register: on each rising clk with reset==1, IR/pc/pc4/ALUout are captured unconditionally. There is no stall or flush input; upstream inserts bubbles as IR=0.
- Address: a = ALUout_M - ADDR_BASE; word index = a[...:2] modulo DM_WORDS (out-of-range wraps silently); byte offset b = a[1:0].
- Store (MemWrite_M==1), committed at the rising edge:
  - SW (0): whole word = WD_M; b ignored.
  - SH (1): half selected by b[1] = WD_M[15:0]; b[0] ignored.
  - SB (2): byte b = WD_M[7:0].
  - Code 3: treated as no write.
- Load: combinational read of the addressed word, lane-select and extend, then captured into DMout_W at the same edge.
  - LW (0): word.
  - LBU (1): zero-extended byte b.
  - LB (2): sign-extended byte b.
  - LHU (3): zero-extended half b[1].
  - LH (4): sign-extended half b[1].
  - Codes 5-7: value 0.
- Latency: data is visible on DMout_W one cycle after the instruction is in M.
- Store/read same cycle: read returns the pre-write contents.
- A store in cycle n followed by a load of the same word in cycle n+1 returns the new data.
- DMout_W is captured every cycle regardless of opcode; W selects it only for loads.
- Reset asserted mid-cycle overrides any pending write; that write is lost.

Optional Feature:
- Macro DM_DISPLAY_EN.
- When defined: each committed store issues a $display at the write edge in the form "@<pc_M hex>: *<word-aligned byte address hex> <= <full resulting word hex>". It is simulation only.
- When undefined: no display code is compiled, and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - SAVE_W/SAVE_H/SAVE_B (2-bit)
  - LOAD_W/LOAD_BU/LOAD_B/LOAD_HU/LOAD_H (3-bit)
  - DM_WORDS default
- One sub-module is natural: dm_load_ext, a purely combinational lane-select plus extend (word, b, load_sel -> 32-bit).
- The store byte-lane mask logic stays inline.

Test Plan:
- Reset low mid-run -> all outputs 0 at once; after release, lw from 0x10 gives DMout_W = 0.
- sw 0x12345678 @0x20, then lw @0x20 next cycle -> DMout_W = 0x12345678 one cycle later.
- sb 0x80 @0x21 over word 0x12345678 -> word 0x12348078; lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080.
- sh 0xBEEF @0x22 -> word 0xBEEF8078; lh @0x22 -> 0xFFFFBEEF; lhu @0x23 (b[0] ignored) -> 0x0000BEEF.
- Same-edge store 0xAAAA_AAAA @0x40 with lw @0x40 in that cycle -> DMout_W = old value (0); the next-cycle lw returns 0xAAAAAAAA.
- Address DM_WORDS*4+0x4 -> wraps to word 1; IR/pc/pc4/ALUout appear on *_W exactly one cycle delayed for a sequence of 5 distinct values.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared store/load width codes and data-memory defaults for the
//            MIPS pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [1:0] SAVE_W  = 2'd0;
   localparam logic [1:0] SAVE_H  = 2'd1;
   localparam logic [1:0] SAVE_B  = 2'd2;

   localparam logic [2:0] LOAD_W  = 3'd0;
   localparam logic [2:0] LOAD_BU = 3'd1;
   localparam logic [2:0] LOAD_B  = 3'd2;
   localparam logic [2:0] LOAD_HU = 3'd3;
   localparam logic [2:0] LOAD_H  = 3'd4;

   localparam int DM_WORDS_DEFAULT = 4096;

endpackage
`default_nettype wire

// File: rtl/dm_load_ext.sv
`default_nettype none
// ============================================================================
// dm_load_ext : combinational lane select and sign/zero extension of a data
//               memory word for lw/lbu/lb/lhu/lh.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_load_ext
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_sel,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = word[7:0];
      case (offset)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      // Halfword lane depends only on offset[1]; offset[0] is ignored.
      w_half = offset[1] ? word[31:16] : word[15:0];

      data = 32'd0;
      case (load_sel)
         LOAD_W:  data = word;
         LOAD_BU: data = {24'd0, w_byte};
         LOAD_B:  data = {{24{w_byte[7]}}, w_byte};
         LOAD_HU: data = {16'd0, w_half};
         LOAD_H:  data = {{16{w_half[15]}}, w_half};
         default: data = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/m_stage_dm.sv
`default_nettype none
// ============================================================================
// m_stage_dm : MIPS memory stage - byte-lane data memory plus M/W register.
//              Define DM_DISPLAY_EN to print every committed store.
// Revision   : 1.0 - initial release
// ============================================================================
module m_stage_dm
   import mips_pkg::*;
#(
   parameter int          DM_WORDS  = DM_WORDS_DEFAULT,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_M,
   input  logic [31:0] pc_M,
   input  logic [31:0] pc4_M,
   input  logic [31:0] ALUout_M,
   input  logic [31:0] WD_M,
   input  logic        MemWrite_M,
   input  logic [1:0]  save_sel_M,
   input  logic [2:0]  load_sel_M,
   output logic [31:0] IR_W,
   output logic [31:0] pc_W,
   output logic [31:0] pc4_W,
   output logic [31:0] ALUout_W,
   output logic [31:0] DMout_W
);

   localparam int c_idx_w = $clog2(DM_WORDS);

   logic [31:0]        r_mem [DM_WORDS];
   logic [31:0]        w_addr;
   logic [c_idx_w-1:0] w_idx;
   logic [1:0]         w_off;
   logic [31:0]        w_rd_word;
   logic [31:0]        w_load_data;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [31:0]        w_new_word;
   logic               w_unused;

   // Upper address bits are dropped, so out-of-range addresses wrap.
   assign w_addr    = ALUout_M - ADDR_BASE;
   assign w_idx     = w_addr[c_idx_w+1:2];
   assign w_off     = w_addr[1:0];
   assign w_unused  = ^w_addr[31:c_idx_w+2];
   assign w_rd_word = r_mem[w_idx];

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = WD_M;
      if (MemWrite_M) begin
         case (save_sel_M)
            SAVE_W: begin
               w_be    = 4'b1111;
               w_wdata = WD_M;
            end
            SAVE_H: begin
               w_be    = w_off[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{WD_M[15:0]}};
            end
            SAVE_B: begin
               w_be    = 4'b0001 << w_off;
               w_wdata = {4{WD_M[7:0]}};
            end
            default: w_be = 4'b0000;
         endcase
      end
   end

   for (genvar l = 0; l < 4; l++) begin : g_lane
      assign w_new_word[8*l +: 8] = w_be[l] ? w_wdata[8*l +: 8] : w_rd_word[8*l +: 8];
   end

   for (genvar i = 0; i < DM_WORDS; i++) begin : g_word
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            r_mem[i] <= 32'd0;
         else if ((|w_be) && (w_idx == c_idx_w'(i)))
            r_mem[i] <= w_new_word;
      end
   end

   dm_load_ext u_load_ext (
      .word     (w_rd_word),
      .offset   (w_off),
      .load_sel (load_sel_M),
      .data     (w_load_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         IR_W     <= 32'd0;
         pc_W     <= 32'd0;
         pc4_W    <= 32'd0;
         ALUout_W <= 32'd0;
         DMout_W  <= 32'd0;
      end else begin
         IR_W     <= IR_M;
         pc_W     <= pc_M;
         pc4_W    <= pc4_M;
         ALUout_W <= ALUout_M;
         DMout_W  <= w_load_data;
      end
   end

`ifdef DM_DISPLAY_EN
   always @(posedge clk) begin
      if (reset && (|w_be))
         $display("@%h: *%h <= %h", pc_M, {ALUout_M[31:2], 2'b00}, w_new_word);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_stage_dm.sv
`default_nettype none
// ============================================================================
// tb_m_stage_dm : self-checking bench for m_stage_dm against a byte-array
//                 memory model.
// Revision      : 1.0 - initial release
// ============================================================================
module tb_m_stage_dm;

   localparam int DM_WORDS = 4096;
   localparam int NBYTES   = DM_WORDS * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] IR_M = '0, pc_M = '0, pc4_M = '0, ALUout_M = '0, WD_M = '0;
   logic        MemWrite_M = 1'b0;
   logic [1:0]  save_sel_M = '0;
   logic [2:0]  load_sel_M = '0;
   logic [31:0] IR_W, pc_W, pc4_W, ALUout_W, DMout_W;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mdl [NBYTES];

   always #5 clk = ~clk;

   m_stage_dm #(.DM_WORDS(DM_WORDS), .ADDR_BASE(32'h0)) dut (
      .clk(clk), .reset(reset), .IR_M(IR_M), .pc_M(pc_M), .pc4_M(pc4_M),
      .ALUout_M(ALUout_M), .WD_M(WD_M), .MemWrite_M(MemWrite_M),
      .save_sel_M(save_sel_M), .load_sel_M(load_sel_M), .IR_W(IR_W),
      .pc_W(pc_W), .pc4_W(pc4_W), .ALUout_W(ALUout_W), .DMout_W(DMout_W)
   );

   task automatic model_clear();
      for (int k = 0; k < NBYTES; k++) mdl[k] = 8'h00;
   endtask

   function automatic int unsigned bidx(input logic [31:0] a);
      return int'(a % NBYTES);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] ls);
      int unsigned p, base, hb;
      logic [31:0] v;
      p    = bidx(a);
      base = p - (p % 4);
      hb   = base + (p % 4 >= 2 ? 2 : 0);
      case (ls)
         3'd0: v = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
         3'd1: v = 32'(mdl[p]);
         3'd2: begin
            v = 32'(mdl[p]);
            if (v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'd3: v = 32'(mdl[hb]) + 256 * 32'(mdl[hb+1]);
         3'd4: begin
            v = 32'(mdl[hb]) + 256 * 32'(mdl[hb+1]);
            if (v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] ss);
      int unsigned p, base, hb;
      p    = bidx(a);
      base = p - (p % 4);
      hb   = base + (p % 4 >= 2 ? 2 : 0);
      case (ss)
         2'd0: begin
            mdl[base]   = wd[7:0];
            mdl[base+1] = wd[15:8];
            mdl[base+2] = wd[23:16];
            mdl[base+3] = wd[31:24];
         end
         2'd1: begin
            mdl[hb]   = wd[7:0];
            mdl[hb+1] = wd[15:8];
         end
         2'd2: mdl[p] = wd[7:0];
         default: ;
      endcase
   endtask

   // Drive one M-stage instruction, advance one edge, return expected DMout_W.
   task automatic step(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] wd,
                       input logic mw, input logic [1:0] ss, input logic [2:0] ls,
                       output logic [31:0] exp_dm);
      IR_M       = ir;
      pc_M       = ir ^ 32'h0040_0000;
      pc4_M      = pc_M + 4;
      ALUout_M   = alu;
      WD_M       = wd;
      MemWrite_M = mw;
      save_sel_M = ss;
      load_sel_M = ls;
      exp_dm     = model_load(alu, ls);
      if (reset && mw) model_store(alu, wd, ss);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      model_clear();
      #2;
      if ({IR_W, pc_W, pc4_W, ALUout_W, DMout_W} !== 160'd0) begin
         $display("FAIL reset_init: got %h %h %h %h %h, want all 0", IR_W, pc_W, pc4_W, ALUout_W, DMout_W);
         n_fail++;
      end
      n_tests++;
      @(posedge clk); #1;
      reset = 1'b1;
      step(32'h1111_0001, 32'h10, 32'h5555_AAAA, 1'b1, 2'd0, 3'd0, e);
      step(32'h1111_0002, 32'h10, 32'h5555_AAAA, 1'b1, 2'd0, 3'd0, e);
      // Mid-cycle reset with a store still pending at the next edge.
      reset = 1'b0;
      #1;
      if ({IR_W, pc_W, pc4_W, ALUout_W, DMout_W} !== 160'd0) begin
         $display("FAIL reset_async: got %h %h %h %h %h, want all 0", IR_W, pc_W, pc4_W, ALUout_W, DMout_W);
         n_fail++;
      end
      n_tests++;
      model_clear();
      @(posedge clk); #1;
      reset = 1'b1;
      step(32'h1111_0003, 32'h10, 32'h0, 1'b0, 2'd0, 3'd0, e);
      if (DMout_W !== 32'd0 || e !== 32'd0) begin
         $display("FAIL reset_lw10: got %h, want 00000000", DMout_W);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_store_load();
      logic [31:0] e;
      logic [31:0] exp_t [7];
      logic [31:0] got_t [7];
      exp_t = '{32'h1234_5678, 32'h1234_8078, 32'hFFFF_FF80, 32'h0000_0080,
                32'hBEEF_8078, 32'hFFFF_BEEF, 32'h0000_BEEF};
      step(32'h2000_0001, 32'h20, 32'h1234_5678, 1'b1, 2'd0, 3'd0, e);
      step(32'h2000_0002, 32'h20, 32'h0, 1'b0, 2'd0, 3'd0, e); got_t[0] = DMout_W;
      step(32'h2000_0003, 32'h21, 32'h0000_0080, 1'b1, 2'd2, 3'd0, e);
      step(32'h2000_0004, 32'h20, 32'h0, 1'b0, 2'd0, 3'd0, e); got_t[1] = DMout_W;
      step(32'h2000_0005, 32'h21, 32'h0, 1'b0, 2'd0, 3'd2, e); got_t[2] = DMout_W;
      step(32'h2000_0006, 32'h21, 32'h0, 1'b0, 2'd0, 3'd1, e); got_t[3] = DMout_W;
      step(32'h2000_0007, 32'h22, 32'h0000_BEEF, 1'b1, 2'd1, 3'd0, e);
      step(32'h2000_0008, 32'h20, 32'h0, 1'b0, 2'd0, 3'd0, e); got_t[4] = DMout_W;
      step(32'h2000_0009, 32'h22, 32'h0, 1'b0, 2'd0, 3'd4, e); got_t[5] = DMout_W;
      step(32'h2000_000A, 32'h23, 32'h0, 1'b0, 2'd0, 3'd3, e); got_t[6] = DMout_W;
      for (int k = 0; k < 7; k++) begin
         if (got_t[k] !== exp_t[k]) begin
            $display("FAIL store_load[%0d]: got %h, want %h", k, got_t[k], exp_t[k]);
            n_fail++;
         end
         n_tests++;
      end
   endtask

   task automatic test_same_edge();
      logic [31:0] e;
      step(32'h3000_0001, 32'h40, 32'hAAAA_AAAA, 1'b1, 2'd0, 3'd0, e);
      if (DMout_W !== 32'd0) begin
         $display("FAIL same_edge_old: got %h, want 00000000", DMout_W);
         n_fail++;
      end
      n_tests++;
      step(32'h3000_0002, 32'h40, 32'h0, 1'b0, 2'd0, 3'd0, e);
      if (DMout_W !== 32'hAAAA_AAAA) begin
         $display("FAIL same_edge_new: got %h, want aaaaaaaa", DMout_W);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_wrap_and_codes();
      logic [31:0] e;
      step(32'h4000_0001, 32'(NBYTES + 4), 32'hCAFE_F00D, 1'b1, 2'd0, 3'd0, e);
      step(32'h4000_0002, 32'h4, 32'h0, 1'b0, 2'd0, 3'd0, e);
      if (DMout_W !== 32'hCAFE_F00D) begin
         $display("FAIL wrap: got %h, want cafef00d", DMout_W);
         n_fail++;
      end
      n_tests++;
      step(32'h4000_0003, 32'h4, 32'h1357_9BDF, 1'b1, 2'd3, 3'd0, e);
      step(32'h4000_0004, 32'h4, 32'h0, 1'b0, 2'd0, 3'd0, e);
      if (DMout_W !== 32'hCAFE_F00D) begin
         $display("FAIL save_code3: got %h, want cafef00d", DMout_W);
         n_fail++;
      end
      n_tests++;
      step(32'h4000_0005, 32'h4, 32'h0, 1'b0, 2'd0, 3'd5, e);
      if (DMout_W !== 32'd0) begin
         $display("FAIL load_code5: got %h, want 00000000", DMout_W);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_pipe_regs();
      logic [31:0] e, ir, alu;
      for (int k = 0; k < 5; k++) begin
         ir  = 32'h5000_0000 + 32'(k * 17 + 3);
         alu = 32'h0000_0100 + 32'(k * 12);
         step(ir, alu, 32'h0, 1'b0, 2'd0, 3'd0, e);
         if (IR_W !== ir || pc_W !== (ir ^ 32'h0040_0000) || pc4_W !== ((ir ^ 32'h0040_0000) + 4)
             || ALUout_W !== alu) begin
            $display("FAIL pipe_regs[%0d]: got ir=%h pc=%h pc4=%h alu=%h, want ir=%h alu=%h",
                     k, IR_W, pc_W, pc4_W, ALUout_W, ir, alu);
            n_fail++;
         end
         n_tests++;
      end
   endtask

   task automatic test_random();
      logic [31:0] e, ir, alu, wd;
      logic        mw;
      logic [1:0]  ss;
      logic [2:0]  ls;
      for (int k = 0; k < 300; k++) begin
         ir  = $urandom;
         alu = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) alu = alu + 32'(NBYTES * $urandom_range(1, 3));
         wd  = $urandom;
         mw  = ($urandom_range(0, 2) == 0);
         ss  = 2'($urandom_range(0, 3));
         ls  = 3'($urandom_range(0, 7));
         step(ir, alu, wd, mw, ss, ls, e);
         if (DMout_W !== e || ALUout_W !== alu || IR_W !== ir) begin
            $display("FAIL random[%0d]: got dm=%h alu=%h ir=%h, want dm=%h alu=%h ir=%h",
                     k, DMout_W, ALUout_W, IR_W, e, alu, ir);
            n_fail++;
         end
         n_tests++;
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_same_edge();
      test_wrap_and_codes();
      test_pipe_regs();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
